memory_arbiter: RTL and testbench

Memory-side responder for the CPU's two L1 caches. Accepts instruction-cache refill reads and data-cache reads and writes, and arbitrates them onto one ROM port, one RAM port and the memory-mapped peripheral registers. Answers each request through a stall/data handshake, tagging every returned word with its source so the caches know whether to allocate. It sits between `l1i`/`l1d` and the backing memories.

---
 rtl/memory_arbiter_pkg.sv | 54 +++++
 rtl/memory_arbiter_if.sv | 25 ++
 rtl/memory_arbiter_input_synchronizer.sv | 25 ++
 rtl/memory_arbiter.sv | 167 ++++++++++++++++
 tb/tb_memory_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the memory arbiter: response source tags, address
// regions, FSM states, grant identifiers, peripheral offsets and the
// address-window decoder.
package memory_arbiter_pkg;

    localparam logic [1:0] DATA_SOURCE_NONE       = 2'd0;
    localparam logic [1:0] DATA_SOURCE_ROM        = 2'd1;
    localparam logic [1:0] DATA_SOURCE_RAM        = 2'd2;
    localparam logic [1:0] DATA_SOURCE_PERIPHERAL = 2'd3;

    localparam logic [31:0] WINDOW_SIZE          = 32'h0000_1000;
    localparam logic [31:0] PERIPH_OUTPUT_OFFSET = 32'h0000_0000;
    localparam logic [31:0] PERIPH_INPUT_OFFSET  = 32'h0000_0004;

    typedef enum logic [1:0] {
        REGION_NONE   = 2'd0,
        REGION_ROM    = 2'd1,
        REGION_RAM    = 2'd2,
        REGION_PERIPH = 2'd3
    } region_t;

    typedef enum logic [1:0] {
        STATE_IDLE   = 2'd0,
        STATE_ACCESS = 2'd1,
        STATE_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_L1I = 1'b0,
        GRANT_L1D = 1'b1
    } grant_t;

    // Unsigned subtraction wraps below the base, so one compare covers the window.
    function automatic region_t decode_region(
        input logic [31:0] address,
        input logic [31:0] rom_base,
        input logic [31:0] ram_base,
        input logic [31:0] periph_base
    );
        region_t region;
        if ((address - rom_base) < WINDOW_SIZE) begin
            region = REGION_ROM;
        end else if ((address - ram_base) < WINDOW_SIZE) begin
            region = REGION_RAM;
        end else if ((address == (periph_base + PERIPH_OUTPUT_OFFSET)) ||
                     (address == (periph_base + PERIPH_INPUT_OFFSET))) begin
            region = REGION_PERIPH;
        end else begin
            region = REGION_NONE;
        end
        return region;
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Cache-side request/response bundle between the L1 caches and the arbiter.
interface memory_arbiter_if;
    logic [31:0] l1i_address;
    logic        l1i_mem_read;
    logic [31:0] l1d_address;
    logic [31:0] l1d_input_data;
    logic        l1d_mem_write;
    logic        l1d_mem_read;
    logic [31:0] output_data;
    logic [1:0]  data_source;
    logic        stall_l1i;
    logic        stall_l1d;

    modport master (
        output l1i_address, l1i_mem_read, l1d_address, l1d_input_data,
               l1d_mem_write, l1d_mem_read,
        input  output_data, data_source, stall_l1i, stall_l1d
    );

    modport slave (
        input  l1i_address, l1i_mem_read, l1d_address, l1d_input_data,
               l1d_mem_write, l1d_mem_read,
        output output_data, data_source, stall_l1i, stall_l1d
    );
endinterface

// File: rtl/memory_arbiter_input_synchronizer.sv
// Two-flop synchronizer for asynchronous switch/button inputs.
module input_synchronizer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);
    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Capture the raw inputs, then re-register to let metastability settle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
        end
    end

    assign sync_out = sync_r;
endmodule

// File: rtl/memory_arbiter.sv
// Memory-side responder for the two L1 caches: arbitrates instruction refills
// and data loads/stores onto ROM, RAM and the peripheral registers, answering
// through a stall/data handshake with a source tag on every returned word.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2,
    parameter logic [31:0] ROM_BASE    = 32'h0000_0000,
    parameter logic [31:0] RAM_BASE    = 32'h0000_1000,
    parameter logic [31:0] PERIPH_BASE = 32'h0000_2000
) (
    input  logic              clock,
    input  logic              reset,
    memory_arbiter_if.slave   cache,
    output logic [9:0]        rom_address,
    input  logic [31:0]       rom_data,
    output logic [9:0]        ram_address,
    output logic [31:0]       ram_write_data,
    output logic              ram_write,
    input  logic [31:0]       ram_data,
    input  logic [3:0]        input_peripherals,
    output logic [3:0]        output_peripherals
);
    localparam logic [3:0] LATENCY_LOAD = 4'(MEM_LATENCY - 1);

    state_t      state_r;
    logic [3:0]  count_r;
    logic [31:0] address_r;
    logic [31:0] write_data_r;
    logic        write_r;
    grant_t      grant_r;
    region_t     region_r;
    logic [9:0]  rom_address_r;
    logic [9:0]  ram_address_r;
    logic        ram_write_r;
    logic [3:0]  output_peripherals_r;

    logic [3:0]  sync_inputs_s;
    logic        data_request_s;
    logic        any_request_s;
    logic [31:0] accept_address_s;
    region_t     accept_region_s;
    logic        periph_output_hit_s;
    logic [31:0] response_data_s;
    logic [1:0]  response_source_s;

    input_synchronizer #(.WIDTH(4)) u_input_synchronizer (
        .clock    (clock),
        .reset    (reset),
        .async_in (input_peripherals),
        .sync_out (sync_inputs_s)
    );

    // The data cache wins whenever both caches ask in the same IDLE cycle.
    assign data_request_s   = cache.l1d_mem_read | cache.l1d_mem_write;
    assign any_request_s    = data_request_s | cache.l1i_mem_read;
    assign accept_address_s = data_request_s ? cache.l1d_address : cache.l1i_address;
    assign accept_region_s  = decode_region(accept_address_s, ROM_BASE, RAM_BASE, PERIPH_BASE);
    assign periph_output_hit_s = ((address_r - PERIPH_BASE) == PERIPH_OUTPUT_OFFSET);

    // Transaction FSM: latch at accept, wait out the memory latency, answer in DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r              <= STATE_IDLE;
            count_r              <= 4'd0;
            address_r            <= 32'h0000_0000;
            write_data_r         <= 32'h0000_0000;
            write_r              <= 1'b0;
            grant_r              <= GRANT_L1I;
            region_r             <= REGION_NONE;
            rom_address_r        <= 10'd0;
            ram_address_r        <= 10'd0;
            ram_write_r          <= 1'b0;
            output_peripherals_r <= 4'd0;
        end else begin
            ram_write_r <= 1'b0;
            case (state_r)
                STATE_IDLE: begin
                    if (any_request_s) begin
                        address_r    <= accept_address_s;
                        write_data_r <= data_request_s ? cache.l1d_input_data : 32'h0000_0000;
                        write_r      <= data_request_s & cache.l1d_mem_write;
                        grant_r      <= data_request_s ? GRANT_L1D : GRANT_L1I;
                        region_r     <= accept_region_s;
                        count_r      <= LATENCY_LOAD;
                        if (accept_region_s == REGION_ROM) begin
                            rom_address_r <= accept_address_s[11:2];
                            state_r       <= STATE_ACCESS;
                        end else if (accept_region_s == REGION_RAM) begin
                            ram_address_r <= accept_address_s[11:2];
                            ram_write_r   <= data_request_s & cache.l1d_mem_write;
                            state_r       <= STATE_ACCESS;
                        end else begin
                            state_r <= STATE_DONE;
                        end
                    end else begin
                        state_r <= STATE_IDLE;
                    end
                end
                STATE_ACCESS: begin
                    if (count_r == 4'd0) begin
                        state_r <= STATE_DONE;
                    end else begin
                        count_r <= count_r - 4'd1;
                    end
                end
                STATE_DONE: begin
                    if (write_r && (region_r == REGION_PERIPH) && periph_output_hit_s) begin
                        output_peripherals_r <= write_data_r[3:0];
                    end else begin
                        output_peripherals_r <= output_peripherals_r;
                    end
                    state_r <= STATE_IDLE;
                end
                default: begin
                    state_r <= STATE_IDLE;
                end
            endcase
        end
    end

    // Response word: memory data arrives in the DONE cycle itself, so it is steered live.
    always_comb begin
        response_data_s   = 32'h0000_0000;
        response_source_s = DATA_SOURCE_NONE;
        if (state_r == STATE_DONE) begin
            case (region_r)
                REGION_ROM: begin
                    response_data_s   = rom_data;
                    response_source_s = DATA_SOURCE_ROM;
                end
                REGION_RAM: begin
                    response_data_s   = ram_data;
                    response_source_s = DATA_SOURCE_RAM;
                end
                REGION_PERIPH: begin
                    response_source_s = DATA_SOURCE_PERIPHERAL;
                    if (periph_output_hit_s) begin
                        response_data_s = {28'h000_0000, output_peripherals_r};
                    end else begin
                        response_data_s = {28'h000_0000, sync_inputs_s};
                    end
                end
                default: begin
                    response_data_s   = 32'h0000_0000;
                    response_source_s = DATA_SOURCE_NONE;
                end
            endcase
        end else begin
            response_data_s   = 32'h0000_0000;
            response_source_s = DATA_SOURCE_NONE;
        end
    end

    assign cache.output_data = response_data_s;
    assign cache.data_source = response_source_s;
    assign cache.stall_l1i   = cache.l1i_mem_read &
                               ~((state_r == STATE_DONE) && (grant_r == GRANT_L1I));
    assign cache.stall_l1d   = data_request_s &
                               ~((state_r == STATE_DONE) && (grant_r == GRANT_L1D));

    assign rom_address        = rom_address_r;
    assign ram_address        = ram_address_r;
    assign ram_write_data     = write_data_r;
    assign ram_write          = ram_write_r;
    assign output_peripherals = output_peripherals_r;
endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: a driver issues directed and random
// cache requests and queues the expected responses from an address-map model;
// a negedge monitor pops and compares whenever a cache's stall drops.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int          L        = 2;
    localparam logic [31:0] ROM_B    = 32'h0000_0000;
    localparam logic [31:0] RAM_B    = 32'h0000_1000;
    localparam logic [31:0] PERIPH_B = 32'h0000_2000;

    typedef struct {
        int          cycle;
        logic [31:0] data;
        logic [1:0]  src;
        bit          check_data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  rom_address, ram_address;
    logic [31:0] rom_data, ram_data, ram_write_data;
    logic        ram_write;
    logic [3:0]  input_peripherals, output_peripherals;

    memory_arbiter_if bus ();

    memory_arbiter #(.MEM_LATENCY(L), .ROM_BASE(ROM_B), .RAM_BASE(RAM_B), .PERIPH_BASE(PERIPH_B)) dut (
        .clock              (clock),
        .reset              (reset),
        .cache              (bus),
        .rom_address        (rom_address),
        .rom_data           (rom_data),
        .ram_address        (ram_address),
        .ram_write_data     (ram_write_data),
        .ram_write          (ram_write),
        .ram_data           (ram_data),
        .input_peripherals  (input_peripherals),
        .output_peripherals (output_peripherals)
    );

    always #5 clock = ~clock;

    int cycle_count = 0;
    always @(posedge clock) cycle_count <= cycle_count + 1;

    // Backing memories: read data appears L cycles after the address.
    logic [31:0] rom_mem [1024];
    logic [31:0] ram_mem [1024];
    logic [9:0]  rom_pipe [L];
    logic [9:0]  ram_pipe [L];
    always @(posedge clock) begin
        if (ram_write) ram_mem[ram_address] <= ram_write_data;
        rom_pipe[0] <= rom_address;
        ram_pipe[0] <= ram_address;
        for (int k = 1; k < L; k++) begin
            rom_pipe[k] <= rom_pipe[k-1];
            ram_pipe[k] <= ram_pipe[k-1];
        end
    end
    assign rom_data = rom_mem[rom_pipe[L-1]];
    assign ram_data = ram_mem[ram_pipe[L-1]];

    // Reference model state
    logic [31:0] ram_shadow [1024];
    logic [3:0]  out_shadow = 4'h0;
    exp_t        q_i[$];
    exp_t        q_d[$];

    int checks   = 0;
    int failures = 0;
    bit timeout_hit = 1'b0, timeout_reported = 1'b0;
    bit final_req = 1'b0, final_done = 1'b0;
    logic prev_ram_write = 1'b0;

    function automatic void model_access(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                                         output logic [31:0] data, output logic [1:0] src, output int lat);
        logic [9:0] idx;
        idx = addr[11:2];
        if (addr >= ROM_B && addr < ROM_B + 32'h1000) begin
            data = rom_mem[idx]; src = 2'd1; lat = L + 1;
        end else if (addr >= RAM_B && addr < RAM_B + 32'h1000) begin
            data = ram_shadow[idx]; src = 2'd2; lat = L + 1;
            if (wr) ram_shadow[idx] = wdata;
        end else if (addr == PERIPH_B) begin
            data = {28'h0, out_shadow}; src = 2'd3; lat = 1;
            if (wr) out_shadow = wdata[3:0];
        end else if (addr == PERIPH_B + 32'h4) begin
            data = {28'h0, input_peripherals}; src = 2'd3; lat = 1;
        end else begin
            data = 32'h0; src = 2'd0; lat = 1;
        end
    endfunction

    task automatic check_exp(input exp_t e, input string name);
        checks++;
        if (cycle_count != e.cycle) begin
            failures++;
            $display("FAIL %s_cycle: done at cycle %0d, expected cycle %0d", name, cycle_count, e.cycle);
        end
        if (e.check_data) begin
            checks++;
            if (bus.output_data !== e.data || bus.data_source !== e.src) begin
                failures++;
                $display("FAIL %s_data: got %h/src %0d, expected %h/src %0d", name,
                         bus.output_data, bus.data_source, e.data, e.src);
            end
        end
    endtask

    // Monitor: all comparisons happen here, away from the active edge.
    always @(negedge clock) begin
        bit d_req, ci, cd;
        exp_t e;
        d_req = bus.l1d_mem_read | bus.l1d_mem_write;
        if (reset) begin
            checks++;
            if (bus.output_data !== 32'h0 || bus.data_source !== 2'd0 || output_peripherals !== 4'h0 ||
                ram_write !== 1'b0 || rom_address !== 10'd0 || ram_address !== 10'd0) begin
                failures++;
                $display("FAIL reset_state: data=%h src=%0d outp=%h ramw=%b roma=%h rama=%h, expected all zero",
                         bus.output_data, bus.data_source, output_peripherals, ram_write, rom_address, ram_address);
            end
            checks++;
            if (bus.stall_l1i !== bus.l1i_mem_read || bus.stall_l1d !== d_req) begin
                failures++;
                $display("FAIL reset_stall: stall_i=%b stall_d=%b, expected %b %b",
                         bus.stall_l1i, bus.stall_l1d, bus.l1i_mem_read, d_req);
            end
            prev_ram_write = 1'b0;
        end else begin
            ci = bus.l1i_mem_read && !bus.stall_l1i;
            cd = d_req && !bus.stall_l1d;
            if (ci) begin
                if (q_i.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL l1i_unexpected: response at cycle %0d, expected none", cycle_count);
                end else begin
                    e = q_i.pop_front();
                    check_exp(e, "l1i");
                end
            end
            if (cd) begin
                if (q_d.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL l1d_unexpected: response at cycle %0d, expected none", cycle_count);
                end else begin
                    e = q_d.pop_front();
                    check_exp(e, "l1d");
                end
            end
            if (!ci && !cd) begin
                checks++;
                if (bus.output_data !== 32'h0 || bus.data_source !== 2'd0) begin
                    failures++;
                    $display("FAIL quiet_output: data=%h src=%0d, expected 0/0", bus.output_data, bus.data_source);
                end
            end
            if (!bus.l1i_mem_read && !d_req && q_i.size() == 0 && q_d.size() == 0) begin
                checks++;
                if (output_peripherals !== out_shadow) begin
                    failures++;
                    $display("FAIL out_periph: got %h, expected %h", output_peripherals, out_shadow);
                end
            end
            if (ram_write) begin
                checks++;
                if (prev_ram_write) begin
                    failures++;
                    $display("FAIL ram_write_pulse: strobe high 2 cycles, expected 1");
                end
            end
            prev_ram_write = ram_write;
        end
        if (timeout_hit && !timeout_reported) begin
            checks++; failures++;
            timeout_reported = 1'b1;
            $display("FAIL handshake_timeout: no response within bound at cycle %0d", cycle_count);
        end
        if (final_req && !final_done) begin
            checks++;
            final_done = 1'b1;
            if (q_i.size() != 0 || q_d.size() != 0) begin
                failures++;
                $display("FAIL leftover: %0d l1i / %0d l1d responses missing, expected 0", q_i.size(), q_d.size());
            end
        end
    end

    task automatic finish_run();
        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic run(input bit use_i, input logic [31:0] a_i, input bit use_d, input bit wr_d,
                       input logic [31:0] a_d, input logic [31:0] wd);
        exp_t e;
        logic [31:0] dt;
        logic [1:0] sr;
        int lat, t, t_d_done;
        bit pend_i, pend_d, done_i, done_d, scramble;
        t = cycle_count;
        t_d_done = t - 1;
        if (use_d) begin
            model_access(a_d, wr_d, wd, dt, sr, lat);
            e = '{t + lat, dt, sr, !wr_d};
            q_d.push_back(e);
            t_d_done = t + lat;
        end
        if (use_i) begin
            model_access(a_i, 1'b0, 32'h0, dt, sr, lat);
            e = '{t_d_done + 1 + lat, dt, sr, 1'b1};
            q_i.push_back(e);
        end
        bus.l1i_address    = a_i;
        bus.l1i_mem_read   = use_i;
        bus.l1d_address    = a_d;
        bus.l1d_input_data = wd;
        bus.l1d_mem_write  = use_d & wr_d;
        bus.l1d_mem_read   = use_d & !wr_d;
        pend_i = use_i;
        pend_d = use_d;
        scramble = !(use_i && use_d);
        for (int n = 0; n < 100 && (pend_i || pend_d); n++) begin
            @(negedge clock);
            done_i = pend_i && !bus.stall_l1i;
            done_d = pend_d && !bus.stall_l1d;
            @(posedge clock);
            #1;
            if (done_i) begin bus.l1i_mem_read = 1'b0; pend_i = 1'b0; end
            if (done_d) begin bus.l1d_mem_read = 1'b0; bus.l1d_mem_write = 1'b0; pend_d = 1'b0; end
            if (scramble && (pend_i || pend_d)) begin
                bus.l1i_address    = $urandom;
                bus.l1d_address    = $urandom;
                bus.l1d_input_data = $urandom;
            end
        end
        if (pend_i || pend_d) begin
            timeout_hit = 1'b1;
            finish_run();
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        logic [31:0] w;
        logic [31:0] edges [4];
        edges[0] = 32'h0000_0FFC; edges[1] = 32'h0000_1FFC;
        edges[2] = 32'h0000_3000; edges[3] = 32'h0000_1000;
        k = $urandom_range(0, 9);
        w = 32'($urandom_range(0, 1023)) << 2;
        case (k)
            0, 1, 2: return ROM_B + w;
            3, 4, 5: return RAM_B + w;
            6:       return PERIPH_B;
            7:       return PERIPH_B + 32'h4;
            8:       return 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC);
            default: return edges[$urandom_range(0, 3)];
        endcase
    endfunction

    initial begin
        logic [31:0] d;
        for (int k = 0; k < 1024; k++) begin
            rom_mem[k] = $urandom;
            ram_mem[k] = $urandom;
            ram_shadow[k] = ram_mem[k];
        end
        for (int k = 0; k < L; k++) begin rom_pipe[k] = 10'd0; ram_pipe[k] = 10'd0; end
        rom_mem[4] = 32'hDEAD_BEEF;
        bus.l1i_address = 32'h0; bus.l1i_mem_read = 1'b0;
        bus.l1d_address = 32'h0; bus.l1d_input_data = 32'h0;
        bus.l1d_mem_write = 1'b0; bus.l1d_mem_read = 1'b0;
        input_peripherals = 4'h0;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);

        // Directed cases from the test plan
        run(1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 32'h0);
        run(1'b1, 32'h0000_0004, 1'b1, 1'b0, 32'h0000_1008, 32'h0);
        run(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_2000, 32'h0000_0005);
        run(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_2000, 32'h0);
        input_peripherals = 4'b1010;
        step(3);
        run(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_2004, 32'h0);
        run(1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 32'h0);

        // RAM write aborted by reset in its second ACCESS cycle
        d = 32'h1234_5678;
        bus.l1d_address = 32'h0000_1004; bus.l1d_input_data = d; bus.l1d_mem_write = 1'b1;
        step(2);
        reset = 1'b1;
        ram_shadow[1] = d;
        out_shadow = 4'h0;
        step(1);
        bus.l1d_mem_write = 1'b0;
        step(1);
        reset = 1'b0;
        step(3);
        run(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_1004, 32'h0);
        run(1'b1, 32'h0000_2000, 1'b0, 1'b0, 32'h0, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            int unsigned kind;
            kind = $urandom_range(0, 4);
            case (kind)
                0: run(1'b1, rand_addr(), 1'b0, 1'b0, 32'h0, 32'h0);
                1: run(1'b0, 32'h0, 1'b1, 1'b0, rand_addr(), $urandom);
                2: run(1'b0, 32'h0, 1'b1, 1'b1, rand_addr(), $urandom);
                3: run(1'b1, rand_addr(), 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                default: begin
                    input_peripherals = 4'($urandom);
                    step(3);
                end
            endcase
            if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
        end

        step(2);
        final_req = 1'b1;
        finish_run();
    end
endmodule
